// File: rtl/multi_rate_ticker_pkg.sv
// Shared constants for the multi-channel ticker: default periods, field widths
// and the symbolic names of the four period-table entries.
package ticker_pkg;

  localparam int PERIOD_SLOWEST = 50_000_000;
  localparam int PERIOD_NORMAL  = 25_000_000;
  localparam int PERIOD_FAST    = 12_500_000;
  localparam int PERIOD_INSANE  = 6_250_000;

  localparam int BEAT_W      = 8;
  localparam int SEL_W       = 2;
  localparam int TABLE_DEPTH = 4;

  typedef enum logic [SEL_W-1:0] {
    RATE_SLOWEST = 2'd0,
    RATE_NORMAL  = 2'd1,
    RATE_FAST    = 2'd2,
    RATE_INSANE  = 2'd3
  } rate_e;

endpackage

// File: rtl/multi_rate_ticker_if.sv
// Period-table configuration bus: a write strobe, the entry index and the new period.
interface multi_rate_ticker_if
  import ticker_pkg::*;
#(
  parameter int WIDTH = 28
);

  logic             cfg_we;
  logic [SEL_W-1:0] cfg_idx;
  logic [WIDTH-1:0] cfg_period;

  modport master (output cfg_we, output cfg_idx, output cfg_period);
  modport slave  (input  cfg_we, input  cfg_idx, input  cfg_period);

endinterface

// File: rtl/multi_rate_ticker_channel.sv
// One tick channel: reloading down-counter, registered tick pulse and a
// wrapping 8-bit beat counter, with restart taking precedence over enable.
module ticker_channel
  import ticker_pkg::*;
#(
  parameter int WIDTH = 28
) (
  input  logic              clock,
  input  logic              reset_b,
  input  logic              enable,
  input  logic              restart,
  input  logic [WIDTH-1:0]  period,
  output logic              tick,
  output logic [BEAT_W-1:0] beat_count
);

  logic [WIDTH-1:0] cnt;

  // The period is sampled only at the reload point, so a rate change never cuts a period short.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      cnt        <= '0;
      tick       <= 1'b0;
      beat_count <= '0;
    end else if (restart) begin
      cnt        <= '0;
      tick       <= 1'b0;
      beat_count <= '0;
    end else if (!enable) begin
      tick <= 1'b0;
    end else if (cnt == '0) begin
      tick       <= 1'b1;
      cnt        <= period - WIDTH'(1);
      beat_count <= beat_count + BEAT_W'(1);
    end else begin
      cnt  <= cnt - WIDTH'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_rate_ticker.sv
// Multi-channel tick generator: a runtime-writable table of four periods shared by
// CHANNELS independent ticker_channel instances, each selecting its own entry.
module multi_rate_ticker
  import ticker_pkg::*;
#(
  parameter int               CHANNELS = 4,
  parameter int               WIDTH    = 28,
  parameter logic [WIDTH-1:0] PERIOD_0 = WIDTH'(PERIOD_SLOWEST),
  parameter logic [WIDTH-1:0] PERIOD_1 = WIDTH'(PERIOD_NORMAL),
  parameter logic [WIDTH-1:0] PERIOD_2 = WIDTH'(PERIOD_FAST),
  parameter logic [WIDTH-1:0] PERIOD_3 = WIDTH'(PERIOD_INSANE)
) (
  input  logic                       clock,
  input  logic                       reset_b,
  input  logic [CHANNELS-1:0]        enable,
  input  logic [CHANNELS-1:0]        restart,
  input  logic [SEL_W*CHANNELS-1:0]  rate_sel,
  multi_rate_ticker_if.slave         cfg,
  output logic [CHANNELS-1:0]        tick,
  output logic [BEAT_W*CHANNELS-1:0] beat_count
);

  logic [WIDTH-1:0] period_table [TABLE_DEPTH];

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      period_table[RATE_SLOWEST] <= PERIOD_0;
      period_table[RATE_NORMAL]  <= PERIOD_1;
      period_table[RATE_FAST]    <= PERIOD_2;
      period_table[RATE_INSANE]  <= PERIOD_3;
    end else if (cfg.cfg_we) begin
      period_table[cfg.cfg_idx] <= cfg.cfg_period;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
    logic [WIDTH-1:0] raw_period;
    logic [WIDTH-1:0] eff_period;

    // A stored zero would underflow the reload, so it is treated as a period of one.
    assign raw_period = period_table[rate_sel[SEL_W*i +: SEL_W]];
    assign eff_period = (raw_period == '0) ? WIDTH'(1) : raw_period;

    ticker_channel #(
      .WIDTH (WIDTH)
    ) u_channel (
      .clock      (clock),
      .reset_b    (reset_b),
      .enable     (enable[i]),
      .restart    (restart[i]),
      .period     (eff_period),
      .tick       (tick[i]),
      .beat_count (beat_count[BEAT_W*i +: BEAT_W])
    );
  end

endmodule

// File: tb/tb_multi_rate_ticker.sv
// Directed bench for multi_rate_ticker with two channels and a 4/3/2/0 period table.
module tb_multi_rate_ticker;
  import ticker_pkg::*;

  localparam int CHANNELS = 2;
  localparam int WIDTH    = 28;

  logic                       clock;
  logic                       reset_b;
  logic [CHANNELS-1:0]        enable;
  logic [CHANNELS-1:0]        restart;
  logic [SEL_W*CHANNELS-1:0]  rate_sel;
  logic [CHANNELS-1:0]        tick;
  logic [BEAT_W*CHANNELS-1:0] beat_count;

  int check_count = 0;
  int error_count = 0;

  int pause_beat [12] = '{1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 3};
  int align_tick [5]  = '{3, 0, 0, 2, 1};

  multi_rate_ticker_if #(.WIDTH(WIDTH)) cfg_bus ();

  multi_rate_ticker #(
    .CHANNELS (CHANNELS),
    .WIDTH    (WIDTH),
    .PERIOD_0 (28'd4),
    .PERIOD_1 (28'd3),
    .PERIOD_2 (28'd2),
    .PERIOD_3 (28'd0)
  ) dut (
    .clock      (clock),
    .reset_b    (reset_b),
    .enable     (enable),
    .restart    (restart),
    .rate_sel   (rate_sel),
    .cfg        (cfg_bus),
    .tick       (tick),
    .beat_count (beat_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Inputs change just after an edge, so each call covers exactly one active edge.
  task automatic applyStimulus(input logic [1:0] en, input logic [1:0] rst_pulse, input logic [3:0] sel);
    enable   = en;
    restart  = rst_pulse;
    rate_sel = sel;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_b            = 1'b0;
    enable             = '0;
    restart            = '0;
    rate_sel           = '0;
    cfg_bus.cfg_we     = 1'b0;
    cfg_bus.cfg_idx    = '0;
    cfg_bus.cfg_period = '0;

    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_tick", 32'(tick), 0);
    checkOutput("reset_beat", 32'(beat_count), 0);
    reset_b = 1'b1;

    $display("[TB] basic cadence, period 4");
    for (int e = 1; e <= 16; e++) begin
      applyStimulus(2'b01, 2'b00, 4'b0000);
      checkOutput($sformatf("cadence_tick_e%0d", e), 32'(tick[0]), 32'(e % 4 == 1));
      if (e % 4 == 1)
        checkOutput($sformatf("cadence_beat_e%0d", e), 32'(beat_count[7:0]), 32'((e + 3) / 4));
    end
    checkOutput("cadence_idle_ch1", 32'({tick[1], beat_count[15:8]}), 0);

    $display("[TB] clamp of stored zero to period 1");
    applyStimulus(2'b00, 2'b11, 4'b0000);
    checkOutput("restart_clears", 32'({tick, beat_count}), 0);
    for (int e = 1; e <= 256; e++) begin
      applyStimulus(2'b01, 2'b00, 4'b0011);
      checkOutput($sformatf("clamp_tick_e%0d", e), 32'(tick[0]), 1);
      if (e == 1 || e == 255 || e == 256)
        checkOutput($sformatf("clamp_beat_e%0d", e), 32'(beat_count[7:0]), 32'(e % 256));
    end

    $display("[TB] pause and resume");
    applyStimulus(2'b00, 2'b01, 4'b0000);
    for (int e = 1; e <= 12; e++) begin
      applyStimulus((e >= 6 && e <= 8) ? 2'b00 : 2'b01, 2'b00, 4'b0000);
      checkOutput($sformatf("pause_tick_e%0d", e), 32'(tick[0]), 32'(e == 1 || e == 5 || e == 12));
      checkOutput($sformatf("pause_beat_e%0d", e), 32'(beat_count[7:0]), 32'(pause_beat[e-1]));
    end

    $display("[TB] aligned restart of both channels");
    repeat (3) applyStimulus(2'b11, 2'b00, 4'b0100);
    applyStimulus(2'b11, 2'b11, 4'b0100);
    checkOutput("align_restart_tick", 32'(tick), 0);
    for (int e = 1; e <= 5; e++) begin
      applyStimulus(2'b11, 2'b00, 4'b0100);
      checkOutput($sformatf("align_tick_e%0d", e), 32'(tick), 32'(align_tick[e-1]));
    end

    $display("[TB] rate change mid-period");
    applyStimulus(2'b00, 2'b01, 4'b0000);
    for (int e = 1; e <= 11; e++) begin
      applyStimulus(2'b01, 2'b00, (e >= 3) ? 4'b0010 : 4'b0000);
      checkOutput($sformatf("rate_tick_e%0d", e), 32'(tick[0]), 32'(e == 1 || (e >= 5 && e % 2 == 1)));
    end

    $display("[TB] table write on a reload edge");
    applyStimulus(2'b00, 2'b10, 4'b0100);
    for (int e = 1; e <= 17; e++) begin
      if (e == 4) begin
        cfg_bus.cfg_we     = 1'b1;
        cfg_bus.cfg_idx    = 2'd1;
        cfg_bus.cfg_period = 28'd5;
      end
      applyStimulus(2'b10, 2'b00, 4'b0100);
      cfg_bus.cfg_we = 1'b0;
      checkOutput($sformatf("write_tick_e%0d", e), 32'(tick[1]),
                  32'(e == 1 || e == 4 || e == 7 || e == 12 || e == 17));
    end

    $display("[TB] asynchronous reset mid-period");
    applyStimulus(2'b00, 2'b11, 4'b1100);
    applyStimulus(2'b11, 2'b00, 4'b1100);
    checkOutput("midreset_pre_tick_e1", 32'(tick), 3);
    applyStimulus(2'b11, 2'b00, 4'b1100);
    checkOutput("midreset_pre_tick_e2", 32'(tick), 2);
    checkOutput("midreset_pre_beat", 32'(beat_count), 32'h0201);
    #2;
    reset_b = 1'b0;
    #1;
    checkOutput("midreset_tick", 32'(tick), 0);
    checkOutput("midreset_beat", 32'(beat_count), 0);
    @(posedge clock);
    #1;
    reset_b = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      applyStimulus(2'b11, 2'b00, 4'b0100);
      checkOutput($sformatf("postreset_tick_e%0d", e), 32'(tick), 32'({e % 3 == 1, e % 4 == 1}));
    end
    checkOutput("postreset_beat", 32'(beat_count), 32'h0303);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
